// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: next-PC select encodings (also used by the controller)
// and default memory-map constants.
package ifu_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned IM_DEPTH_DEFAULT = 4096;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      NPC_PC4 = 2'b00,
      NPC_J   = 2'b01,
      NPC_BR  = 2'b10,
      NPC_JR  = 2'b11
   } npc_op_e;

   // Last word-aligned byte address covered by an IM of the given depth.
   function automatic logic [31:0] im_last_addr(input logic [31:0] base, input int unsigned depth);
      return base + 32'(4 * depth) - 32'd4;
   endfunction

endpackage

// File: rtl/ifu_if.sv
// Controller <-> fetch unit bundle: control toward the IFU, fetched instruction and status back.
interface ifu_if;
   import ifu_pkg::*;

   logic            en;
   npc_op_e         npc_op;
   logic            cmp_true;
   logic [XLEN-1:0] ra;

   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic            fault;
   logic [XLEN-1:0] icount;

   modport master (
      output en, npc_op, cmp_true, ra,
      input  instr, pc, pc_plus4, fault, icount
   );

   modport slave (
      input  en, npc_op, cmp_true, ra,
      output instr, pc, pc_plus4, fault, icount
   );

endinterface

// File: rtl/ifu_npc.sv
// Next-PC target selection and legality check against the IM address window.
module ifu_npc
   import ifu_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int unsigned IM_DEPTH = IM_DEPTH_DEFAULT
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [25:0]     imm26_i,
   input  npc_op_e         npc_op_i,
   input  logic            cmp_true_i,
   input  logic [XLEN-1:0] ra_i,
   output logic [XLEN-1:0] target_o,
   output logic            legal_o
);

   localparam logic [31:0] PC_LAST = im_last_addr(PC_RESET, IM_DEPTH);

   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] br_off;

   assign pc4    = pc_i + 32'd4;
   assign br_off = {{14{imm26_i[15]}}, imm26_i[15:0], 2'b00};

   always_comb begin
      target_o = pc4;
      unique case (npc_op_i)
         NPC_PC4: target_o = pc4;
         NPC_J:   target_o = {pc_i[31:28], imm26_i, 2'b00};
         NPC_BR:  target_o = cmp_true_i ? (pc4 + br_off) : pc4;
         NPC_JR:  target_o = ra_i;
      endcase
   end

   // Wrapped arithmetic lands outside the window and is rejected here.
   assign legal_o = (target_o[1:0] == 2'b00) && (target_o >= PC_RESET) && (target_o <= PC_LAST);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, read-only instruction ROM, sticky fetch fault
// and retired-instruction counter.
module ifu
   import ifu_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int unsigned IM_DEPTH = IM_DEPTH_DEFAULT,
   parameter logic [31:0] IM_INIT [IM_DEPTH] = '{default: 32'h0000_0000}
) (
   input  logic  clk,
   input  logic  reset,
   ifu_if.slave  bus
);

   localparam int unsigned AW       = $clog2(IM_DEPTH);
   localparam logic [31:0] IM_BYTES = 32'(4 * IM_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] icount_q, icount_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] offset;
   logic            in_range;
   logic [AW-1:0]   word_idx;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] target;
   logic            legal;

   // ROM read; an out-of-window PC fetches a nop.
   assign offset   = pc_q - PC_RESET;
   assign in_range = offset < IM_BYTES;
   assign word_idx = offset[AW+1:2];
   assign instr    = in_range ? IM_INIT[word_idx] : 32'h0000_0000;

   ifu_npc #(
      .PC_RESET (PC_RESET),
      .IM_DEPTH (IM_DEPTH)
   ) u_npc (
      .pc_i       (pc_q),
      .imm26_i    (instr[25:0]),
      .npc_op_i   (bus.npc_op),
      .cmp_true_i (bus.cmp_true),
      .ra_i       (bus.ra),
      .target_o   (target),
      .legal_o    (legal)
   );

   // A rejected target freezes PC and counter and latches the fault.
   always_comb begin
      pc_d     = pc_q;
      icount_d = icount_q;
      fault_d  = fault_q;
      if (bus.en) begin
         if (legal) begin
            pc_d     = target;
            icount_d = icount_q + 32'd1;
         end else begin
            fault_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q     <= PC_RESET;
         icount_q <= '0;
         fault_q  <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         icount_q <= icount_d;
         fault_q  <= fault_d;
      end
   end

   assign bus.instr    = instr;
   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = pc_q + 32'd4;
   assign bus.fault    = fault_q;
   assign bus.icount   = icount_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios followed by a randomized run against a
// behavioural next-PC model.
module tb_ifu;
   import ifu_pkg::*;

   localparam logic [31:0] PCR   = 32'h0000_3000;
   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] IMG [DEPTH] = '{
      0:  32'h0C00_0C10, 1:  32'h2010_0005, 2:  32'h1000_FFFE, 3:  32'h0000_0020,
      4:  32'h1085_0003, 5:  32'h0800_0C02, 6:  32'h1211_FFF8, 7:  32'h3C01_0001,
      8:  32'h1000_8000, 9:  32'h0800_1BFF, 10: 32'h1000_0FFF, 11: 32'h03E0_0008,
      12: 32'h1000_FFF0, 13: 32'h0800_0C00, 14: 32'hAC22_0004, 15: 32'h1000_0001,
      16: 32'h2402_000A, 4095: 32'hDEAD_BEEF,
      default: 32'h0000_0000
   };

   logic clk = 1'b0;
   logic reset;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   ifu_if bus ();

   ifu #(
      .PC_RESET (PCR),
      .IM_DEPTH (DEPTH),
      .IM_INIT  (IMG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst_n, input logic e, input npc_op_e op,
                       input logic c, input logic [31:0] r);
      reset        = rst_n;
      bus.en       = e;
      bus.npc_op   = op;
      bus.cmp_true = c;
      bus.ra       = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_instr(input logic [31:0] p);
      if (p >= PCR && (p - PCR) < 32'(4 * DEPTH)) return IMG[(p - PCR) / 4];
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_target(input logic [31:0] p, input logic [31:0] ins,
                                            input npc_op_e op, input logic c, input logic [31:0] r);
      int off;
      off = int'($signed(ins[15:0]));
      case (op)
         NPC_J:   return (p & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
         NPC_BR:  return c ? (p + 32'd4 + 32'(off * 4)) : (p + 32'd4);
         NPC_JR:  return r;
         default: return p + 32'd4;
      endcase
   endfunction

   function automatic bit m_legal(input logic [31:0] t);
      return (t % 4 == 0) && (t >= PCR) && ((t - PCR) < 32'(4 * DEPTH));
   endfunction

   initial begin
      logic [31:0] m_pc, m_ic, t, r;
      logic        m_fault, rst_n, e, c;
      npc_op_e     op;

      // Reset for two cycles
      step(1'b0, 1'b0, NPC_PC4, 1'b0, 32'h0);
      step(1'b0, 1'b0, NPC_PC4, 1'b0, 32'h0);
      chk("rst_pc", bus.pc, 32'h3000);
      chk("rst_fault", 32'(bus.fault), 32'h0);
      chk("rst_icount", bus.icount, 32'h0);
      chk("rst_instr", bus.instr, 32'h0C00_0C10);
      chk("rst_pc4", bus.pc_plus4, 32'h3004);

      // Sequential fetch
      step(1'b1, 1'b1, NPC_PC4, 1'b0, 32'h0);
      chk("seq_pc1", bus.pc, 32'h3004);
      chk("seq_in1", bus.instr, 32'h2010_0005);
      step(1'b1, 1'b1, NPC_PC4, 1'b0, 32'h0);
      chk("seq_pc2", bus.pc, 32'h3008);
      chk("seq_in2", bus.instr, 32'h1000_FFFE);
      step(1'b1, 1'b1, NPC_PC4, 1'b0, 32'h0);
      chk("seq_pc3", bus.pc, 32'h300C);
      chk("seq_in3", bus.instr, 32'h0000_0020);
      chk("seq_icount", bus.icount, 32'd3);
      chk("seq_pc4", bus.pc_plus4, 32'h3010);

      // Backward branch taken / not taken at 3008
      step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h3008);
      chk("jr_3008", bus.pc, 32'h3008);
      step(1'b1, 1'b1, NPC_BR, 1'b1, 32'h0);
      chk("br_taken", bus.pc, 32'h3004);
      step(1'b1, 1'b1, NPC_PC4, 1'b0, 32'h0);
      step(1'b1, 1'b1, NPC_BR, 1'b0, 32'h0);
      chk("br_not_taken", bus.pc, 32'h300C);

      // jal from 3000
      step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h3000);
      bus.npc_op = NPC_J;
      #1;
      chk("jal_instr", bus.instr, 32'h0C00_0C10);
      chk("jal_link", bus.pc_plus4, 32'h3004);
      step(1'b1, 1'b1, NPC_J, 1'b0, 32'h0);
      chk("jal_pc", bus.pc, 32'h3040);
      chk("jal_icount", bus.icount, 32'd9);

      // Illegal jr targets, then a legal one
      step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h3002);
      chk("jr_misal_pc", bus.pc, 32'h3040);
      chk("jr_misal_fault", 32'(bus.fault), 32'h1);
      chk("jr_misal_icount", bus.icount, 32'd9);
      step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h7000);
      chk("jr_oor_pc", bus.pc, 32'h3040);
      chk("jr_oor_icount", bus.icount, 32'd9);
      step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h3010);
      chk("jr_ok_pc", bus.pc, 32'h3010);
      chk("jr_ok_fault", 32'(bus.fault), 32'h1);
      chk("jr_ok_icount", bus.icount, 32'd10);

      // Enable low holds; reset wins over enable
      step(1'b1, 1'b0, NPC_JR, 1'b0, 32'h3020);
      step(1'b1, 1'b0, NPC_JR, 1'b0, 32'h3020);
      chk("en0_pc", bus.pc, 32'h3010);
      chk("en0_icount", bus.icount, 32'd10);
      step(1'b0, 1'b1, NPC_JR, 1'b0, 32'h3020);
      chk("rst_pri_pc", bus.pc, 32'h3000);
      chk("rst_pri_fault", 32'(bus.fault), 32'h0);
      chk("rst_pri_icount", bus.icount, 32'h0);

      // Last IM word: falling through is illegal
      step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h6FFC);
      chk("last_pc", bus.pc, 32'h6FFC);
      chk("last_instr", bus.instr, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, NPC_PC4, 1'b0, 32'h0);
      chk("edge_pc", bus.pc, 32'h6FFC);
      chk("edge_fault", 32'(bus.fault), 32'h1);
      chk("edge_icount", bus.icount, 32'd1);

      // Randomized run against the reference model
      step(1'b0, 1'b0, NPC_PC4, 1'b0, 32'h0);
      m_pc    = PCR;
      m_ic    = 32'h0;
      m_fault = 1'b0;
      for (int i = 0; i < 500; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         e     = ($urandom_range(0, 4) != 0);
         op    = npc_op_e'(2'($urandom_range(0, 3)));
         c     = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0, 1:    r = PCR + 32'(4 * $urandom_range(0, 16));
            2:       r = PCR + 32'($urandom_range(0, 63));
            default: r = ($urandom_range(0, 1) == 1) ? 32'h6FF8 + 32'(4 * $urandom_range(0, 2))
                                                     : 32'($urandom);
         endcase
         t = m_target(m_pc, m_instr(m_pc), op, c, r);
         if (!rst_n) begin
            m_pc    = PCR;
            m_ic    = 32'h0;
            m_fault = 1'b0;
         end else if (e) begin
            if (m_legal(t)) begin
               m_pc = t;
               m_ic = m_ic + 32'd1;
            end else begin
               m_fault = 1'b1;
            end
         end
         step(rst_n, e, op, c, r);
         chk("rnd_pc", bus.pc, m_pc);
         chk("rnd_instr", bus.instr, m_instr(m_pc));
         chk("rnd_pc4", bus.pc_plus4, m_pc + 32'd4);
         chk("rnd_fault", 32'(bus.fault), 32'(m_fault));
         chk("rnd_icount", bus.icount, m_ic);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit for the single-cycle MIPS core.
- It sits directly upstream of the controller: it holds the PC, reads the instruction word from on-chip instruction memory, and drives the instruction to the controller and datapath.
- It computes the next PC from the controller's NPCop, the branch compare result and the jr register value.
- It also latches a sticky fetch-fault flag and keeps a retired-instruction counter.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; also the byte address of IM word 0.
- IM_DEPTH, 4096, number of 32-bit instruction words.
- IM_FILE, "code.txt", hex image loaded into IM at elaboration.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- en  input  1  advance enable; 0 holds PC and counter.
- npc_op  input  2  next-PC select from the controller: 00 PC+4, 01 j/jal, 10 conditional branch (beq/bsoal), 11 jr.
- cmp_true  input  1  branch condition result from the comparator; only used when npc_op==10.
- ra  input  32  GRF rs value, the jr target.
- instr  output  32  instruction at the current PC (combinational read).
- pc  output  32  current PC.
- pc_plus4  output  32  pc+4, the link value for jal/bsoal.
- fault  output  1  sticky: a rejected next-PC was seen.
- icount  output  32  count of cycles in which the PC advanced.

Behaviour:
- Reset (reset==0 at posedge): pc=PC_RESET, fault=0, icount=0. This has priority over en and over every other input. A reset asserted mid-run discards any pending target.
- Read path (combinational):
  - instr = IM[(pc-PC_RESET)>>2], indexed by address bits [log2(IM_DEPTH)+1:2] of the offset.
  - If pc is outside the IM range, instr=32'h0000_0000 (nop).
- Target computation (combinational, sub-module npc):
  - 00: pc+4.
  - 01: {pc[31:28], instr[25:0], 2'b00}.
  - 10: cmp_true ? pc+4+(sext(instr[15:0])<<2) : pc+4.
  - 11: ra.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is not special-cased. The range check below catches it.
- Legal target: target[1:0]==2'b00 AND PC_RESET <= target <= PC_RESET+4*IM_DEPTH-4.
- Update at posedge, when reset==1 and en==1:
  - Legal target: pc<=target, icount<=icount+1.
  - Illegal target: pc holds, icount holds, fault<=1.
  - fault stays 1 until reset, and later legal targets do not clear it.
- en==0: pc, icount and fault all hold. The target is still computed but has no effect.
- icount wraps from 32'hFFFF_FFFF to 0 silently.
- pc_plus4 is always pc+4, independent of npc_op.
- Latency:
  - instr, pc and pc_plus4 are valid in the same cycle as the PC they belong to.
  - A new PC is visible one cycle after the edge that captures it.
- IM is read-only. It is initialised with $readmemh(IM_FILE), and words not present in the file read as 0.

Decomposition:
- Shared package/header `mips_defs` holds:
  - NPC_PC4=2'b00, NPC_J=2'b01, NPC_BR=2'b10, NPC_JR=2'b11.
  - PC_RESET default 32'h0000_3000.
  - The same encodings are used by the controller.
- Sub-module npc: purely combinational target computation plus the legality check (outputs target, legal).
- ifu holds the PC register, IM array, fault flag and icount.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: hold reset=0 two cycles, release, en=1, npc_op=00 for 3 cycles.
  - Response: pc goes 3000, 3004, 3008, 300C; instr matches IM words 0..3; icount=3; pc_plus4=3010.
- Backward branch:
  - Stimulus: at pc=3008 with instr[15:0]=16'hFFFE, npc_op=10, cmp_true=1.
  - Response: next pc=3004.
  - Repeat with cmp_true=0: next pc=300C.
- Jump:
  - Stimulus: at pc=3000 with instr=0x0C000C10 (jal, imm26=0x000C10), npc_op=01.
  - Response: next pc=3040; pc_plus4=3004 during the jal cycle.
- jr with illegal targets:
  - Stimulus: npc_op=11, ra=32'h0000_3002.
  - Response: pc holds, fault=1, icount unchanged.
  - Then ra=32'h0000_7000 (first out-of-range address) gives the same result.
  - Then ra=32'h0000_3010: pc=3010, fault still 1.
- Enable and reset priority:
  - Stimulus: en=0 for 2 cycles with npc_op=11, ra=3020.
  - Response: pc holds. Then reset=0 together with en=1 gives pc=3000, fault=0, icount=0.
- Boundary:
  - Stimulus: pc=6FFC (last word), npc_op=00.
  - Response: target 7000 is illegal, so pc stays 6FFC and fault=1.
